// File: rtl/lpc_frame_sequencer.sv
// lpc_frame_sequencer: per-frame controller for the LPC chain (autocorr, lag window, Levinson, Az-to-LSP).
// Define LPC_SEQ_TIMEOUT_EN to add a per-stage watchdog that reports through o_timeout_err.
module lpc_frame_sequencer #(
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_frame_start,
  input  logic       i_autocorr_done,
  input  logic       i_lag_done,
  input  logic       i_lev_done,
  input  logic       i_lsp_done,
  output logic       o_autocorr_start,
  output logic       o_lag_start,
  output logic       o_lev_start,
  output logic       o_lsp_start,
  output logic [1:0] o_mem_mux_sel,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic [7:0] o_frame_count,
  output logic       o_overrun,
  output logic       o_timeout_err
);
  typedef enum logic [3:0] {IDLE, S_AC, W_AC, S_LAG, W_LAG, S_LEV, W_LEV, S_LSP, W_LSP, FIN} state_t;
  state_t r_state;
  logic   r_pend;
  logic   w_to;
`ifdef LPC_SEQ_TIMEOUT_EN
  logic [11:0] r_cnt;
  logic        r_terr;
  logic        w_wait;
  logic        w_done;
  assign w_wait = r_state inside {W_AC, W_LAG, W_LEV, W_LSP};
  assign w_done = (r_state == W_AC && i_autocorr_done) || (r_state == W_LAG && i_lag_done) ||
                  (r_state == W_LEV && i_lev_done) || (r_state == W_LSP && i_lsp_done);
  assign w_to = w_wait && !w_done && (r_cnt == 12'(TIMEOUT_CYCLES - 1));
  assign o_timeout_err = r_terr;
  // Leaving a W state always passes through a non-W state, so the counter is 0 on every W entry
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_cnt  <= '0;
      r_terr <= 1'b0;
    end else begin
      r_cnt <= w_wait ? r_cnt + 12'd1 : 12'd0;
      if (w_to) r_terr <= 1'b1;
    end
`else
  assign w_to = 1'b0;
  assign o_timeout_err = 1'b0;
`endif
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state          <= IDLE;
      r_pend           <= 1'b0;
      o_autocorr_start <= 1'b0;
      o_lag_start      <= 1'b0;
      o_lev_start      <= 1'b0;
      o_lsp_start      <= 1'b0;
      o_mem_mux_sel    <= 2'd0;
      o_busy           <= 1'b0;
      o_frame_done     <= 1'b0;
      o_frame_count    <= 8'd0;
      o_overrun        <= 1'b0;
    end else begin
      o_autocorr_start <= 1'b0;
      o_lag_start      <= 1'b0;
      o_lev_start      <= 1'b0;
      o_lsp_start      <= 1'b0;
      o_frame_done     <= 1'b0;
      if (i_frame_start && r_state != IDLE) begin
        if (r_pend) o_overrun <= 1'b1;
        r_pend <= 1'b1;
      end
      case (r_state)
        IDLE: if (i_frame_start || r_pend) begin
          r_state          <= S_AC;
          r_pend           <= i_frame_start && r_pend;
          o_autocorr_start <= 1'b1;
          o_mem_mux_sel    <= 2'd1;
          o_busy           <= 1'b1;
        end
        S_AC:  r_state <= W_AC;
        W_AC:  if (i_autocorr_done) begin
          r_state       <= S_LAG;
          o_lag_start   <= 1'b1;
          o_mem_mux_sel <= 2'd2;
        end
        S_LAG: r_state <= W_LAG;
        W_LAG: if (i_lag_done) begin
          r_state       <= S_LEV;
          o_lev_start   <= 1'b1;
          o_mem_mux_sel <= 2'd3;
        end
        S_LEV: r_state <= W_LEV;
        W_LEV: if (i_lev_done) begin
          r_state     <= S_LSP;
          o_lsp_start <= 1'b1;
        end
        S_LSP: r_state <= W_LSP;
        W_LSP: if (i_lsp_done) begin
          r_state       <= FIN;
          o_frame_done  <= 1'b1;
          o_mem_mux_sel <= 2'd0;
        end
        FIN: begin
          r_state       <= IDLE;
          o_busy        <= 1'b0;
          o_frame_count <= o_frame_count + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
      // A stalled stage abandons the frame and any queued request
      if (w_to) begin
        r_state       <= IDLE;
        r_pend        <= 1'b0;
        o_mem_mux_sel <= 2'd0;
        o_busy        <= 1'b0;
      end
    end
endmodule
